// File: rtl/sm_data_memory.sv
// S-Machine data memory responder: handshaked data port with wait states and a
// write-protected low region, plus an independent one-cycle-latency fetch port.
module sm_data_memory #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned WP_LIMIT    = 32'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              read_write_memory,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_out_memory,
  output logic [DATA_W-1:0] data_in_memory,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] inst
);

  localparam int unsigned        DEPTH = 1 << ADDR_W;
  localparam int unsigned        CNT_W = 4;
  localparam logic [CNT_W-1:0]   WS    = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_W-1:0]  WP    = ADDR_W'(WP_LIMIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              lat_rw, lat_rw_nx;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nx;
  logic              ack_nx, err_nx, busy_nx;
  logic [DATA_W-1:0] rdata_nx;

  // Completion operands: the live inputs when a zero-wait request completes on
  // its acceptance edge, the latched copy otherwise.
  logic              fin;
  logic              fin_rw;
  logic [ADDR_W-1:0] fin_addr;
  logic [DATA_W-1:0] fin_wdata;
  logic              we;

  // Next-state, request latching and completion decode.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    lat_rw_nx    = lat_rw;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    ack_nx       = 1'b0;
    err_nx       = 1'b0;
    busy_nx      = busy;
    rdata_nx     = data_in_memory;
    fin          = 1'b0;
    fin_rw       = lat_rw;
    fin_addr     = lat_addr;
    fin_wdata    = lat_wdata;
    we           = 1'b0;

    case (state)
      S_IDLE: begin
        if (req) begin
          lat_rw_nx    = read_write_memory;
          lat_addr_nx  = addr;
          lat_wdata_nx = data_out_memory;
          cnt_nx       = WS;
          busy_nx      = 1'b1;
          if (WS == '0) begin
            state_nx  = S_RESP;
            fin       = 1'b1;
            fin_rw    = read_write_memory;
            fin_addr  = addr;
            fin_wdata = data_out_memory;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nx = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nx = S_RESP;
          fin      = 1'b1;
        end
      end
      S_RESP: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
      end
    endcase

    if (fin) begin
      ack_nx = 1'b1;
      if (fin_rw) begin
        if (fin_addr >= WP) we = 1'b1;
        else                err_nx = 1'b1;
      end else begin
        rdata_nx = mem[fin_addr];
      end
    end
  end

  // FSM state, latched request and registered data-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      lat_rw         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      ack            <= 1'b0;
      err            <= 1'b0;
      busy           <= 1'b0;
      data_in_memory <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      lat_rw         <= lat_rw_nx;
      lat_addr       <= lat_addr_nx;
      lat_wdata      <= lat_wdata_nx;
      ack            <= ack_nx;
      err            <= err_nx;
      busy           <= busy_nx;
      data_in_memory <= rdata_nx;
    end
  end

  // RAM write; array is not reset, and a request is never committed under reset.
  always_ff @(posedge clk) begin
    if (we && rst_n) mem[fin_addr] <= fin_wdata;
  end

  // Fetch port: read-before-write on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inst <= '0;
    else        inst <= mem[PC];
  end

endmodule
